reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchroniser flops on each asynchronous input.
REQ-002 Parameter LOCK_FILTER, default 1024: consecutive cycles of synchronised lock required before reset release begins.
REQ-003 Parameter SDRAM_HOLD, default 256: cycles sdram_reset is held after lock filtering completes.
REQ-004 Parameter READY_TIMEOUT, default 65535: maximum cycles to wait for sdram_ready.
REQ-005 clk  in  1  system clock, PLL output c0; the only clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pll_locked  in  1  PLL lock indicator, asynchronous to clk.
REQ-008 btn_reset  in  1  user reset button, asynchronous, active-high.
REQ-009 sdram_ready  in  1  SDRAM controller initialisation complete, clk domain.
REQ-010 sdram_reset  out  1  active-high reset to the SDRAM controller.
REQ-011 core_reset_n  out  1  active-low reset to the core.
REQ-012 ready_timeout  out  1  sticky flag: RUN was entered via timeout.
REQ-013 relock_count  out  8  saturating count of lock/button aborts.
REQ-014 state_dbg  out  3  current state encoding.

Function
REQ-015 pll_locked and btn_reset SHALL each pass through SYNC_STAGES flops; only the synchronised versions (locked_s, btn_s) are used.
REQ-016 States: WAIT_LOCK, FILTER, SDRAM_RST, WAIT_READY, RUN.
REQ-017 A single counter SHALL be used, sized clog2 of the largest of LOCK_FILTER, SDRAM_HOLD and READY_TIMEOUT, and cleared on every state entry.
REQ-018 WAIT_LOCK -> FILTER when locked_s=1 and btn_s=0.
REQ-019 FILTER -> SDRAM_RST when the counter equals LOCK_FILTER-1, so FILTER occupies exactly LOCK_FILTER cycles.
REQ-020 SDRAM_RST -> WAIT_READY when the counter equals SDRAM_HOLD-1.
REQ-021 WAIT_READY -> RUN when sdram_ready=1.
REQ-022 WAIT_READY -> RUN when the counter equals READY_TIMEOUT-1 with sdram_ready=0, setting ready_timeout; sdram_ready=1 on the same cycle takes priority and leaves ready_timeout clear.
REQ-023 Abort: in any state other than WAIT_LOCK, locked_s=0 or btn_s=1 SHALL force WAIT_LOCK on the next edge and override all other transitions.
REQ-024 Each abort SHALL increment relock_count, which saturates at 255.
REQ-025 sdram_reset=1 in WAIT_LOCK, FILTER and SDRAM_RST; 0 otherwise.
REQ-026 core_reset_n=1 only in RUN.
REQ-027 Both outputs SHALL be registered, decoded from next-state so they change on the same edge as the state; they are glitch-free.
REQ-028 ready_timeout SHALL clear only on reset or on entry to SDRAM_RST.
REQ-029 A parameter value of 0 SHALL be treated as 1.

Reset
REQ-030 On reset=1: state WAIT_LOCK, counter 0, sdram_reset=1, core_reset_n=0, ready_timeout=0, relock_count=0, synchroniser flops 0.
REQ-031 Reset asserted mid-sequence, including in RUN, SHALL take effect on the next edge and SHALL NOT increment relock_count.

Structure
REQ-032 State encoding constants and default parameter values SHALL live in the shared package reset_seq_pkg.
REQ-033 One sub-module, sync_bit (parameterised depth, 1-bit, reset to 0), SHALL be instantiated twice.

Verification (SYNC_STAGES=2, LOCK_FILTER=8, SDRAM_HOLD=4, READY_TIMEOUT=16; edge 0 = first edge with pll_locked=1 after reset)
REQ-034 Nominal sequence: sdram_ready tied 1 -> FILTER at edge 2, sdram_reset falls at edge 14, core_reset_n rises at edge 15, ready_timeout=0.
REQ-035 Timeout: sdram_ready tied 0 -> RUN entered at edge 30 (core_reset_n rises), ready_timeout=1.
REQ-036 Glitch in FILTER: pll_locked low for 3 cycles starting edge 5 -> return to WAIT_LOCK, relock_count=1, filter restarts with full 8-cycle count on relock.
REQ-037 Button press: btn_reset pulsed 2 cycles in RUN -> core_reset_n=0 and sdram_reset=1 within 3 edges, relock_count=1, full sequence repeats after release.
REQ-038 Saturation: 300 forced aborts -> relock_count=255.
REQ-039 Reset priority: reset asserted in WAIT_READY together with sdram_ready=1 -> WAIT_LOCK, all outputs at reset values, no RUN entry.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// ----------------------------------------------------------------------------
// reset_seq_pkg
// Shared definitions for the reset sequencer: default parameter values, the
// 3-bit state encodings (also visible on state_dbg) and small constant helper
// functions used to size and sanitise parameters.
// No ports.
// ----------------------------------------------------------------------------
package reset_seq_pkg;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_LOCK_FILTER   = 1024;
  localparam int DEF_SDRAM_HOLD    = 256;
  localparam int DEF_READY_TIMEOUT = 65535;

  localparam logic [2:0] ST_WAIT_LOCK  = 3'd0;
  localparam logic [2:0] ST_FILTER     = 3'd1;
  localparam logic [2:0] ST_SDRAM_RST  = 3'd2;
  localparam logic [2:0] ST_WAIT_READY = 3'd3;
  localparam logic [2:0] ST_RUN        = 3'd4;

  // A zero (or negative) configuration value behaves as 1.
  function automatic int at_least_one(input int v);
    if (v < 1) begin
      return 1;
    end else begin
      return v;
    end
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_bit.sv
// ----------------------------------------------------------------------------
// sync_bit
// Single-bit synchroniser chain of STAGES flops (0 behaves as 1), cleared by
// the synchronous reset.
// Ports: clk   - destination clock
//        reset - synchronous active-high reset, clears every stage to 0
//        d     - asynchronous input
//        q     - synchronised output (last stage)
// ----------------------------------------------------------------------------
module sync_bit
  import reset_seq_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  localparam int N = at_least_one(STAGES);

  logic [N-1:0] chain_r;

  generate
    if (N == 1) begin : g_single
      // Single-stage capture of the asynchronous input.
      always_ff @(posedge clk) begin
        if (reset) begin
          chain_r <= 1'b0;
        end else begin
          chain_r <= d;
        end
      end
    end else begin : g_multi
      // Shift the asynchronous input through the synchroniser chain.
      always_ff @(posedge clk) begin
        if (reset) begin
          chain_r <= '0;
        end else begin
          chain_r <= {chain_r[N-2:0], d};
        end
      end
    end
  endgenerate

  assign q = chain_r[N-1];

endmodule

// File: rtl/reset_sequencer.sv
// ----------------------------------------------------------------------------
// reset_sequencer
// Power-up / button reset sequencer: waits for a filtered PLL lock, holds the
// SDRAM controller in reset for a while, waits (bounded) for SDRAM init and
// then releases the core. Losing lock or pressing the button restarts it.
// Ports: clk           - system clock (PLL c0), all logic on rising edge
//        reset         - synchronous active-high reset
//        pll_locked    - PLL lock, asynchronous
//        btn_reset     - user reset button, asynchronous, active-high
//        sdram_ready   - SDRAM init complete (clk domain)
//        sdram_reset   - registered active-high SDRAM controller reset
//        core_reset_n  - registered active-low core reset
//        ready_timeout - sticky: RUN was reached through the timeout
//        relock_count  - saturating count of lock/button aborts
//        state_dbg     - current state encoding
// ----------------------------------------------------------------------------
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int LOCK_FILTER   = DEF_LOCK_FILTER,
  parameter int SDRAM_HOLD    = DEF_SDRAM_HOLD,
  parameter int READY_TIMEOUT = DEF_READY_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       btn_reset,
  input  logic       sdram_ready,
  output logic       sdram_reset,
  output logic       core_reset_n,
  output logic       ready_timeout,
  output logic [7:0] relock_count,
  output logic [2:0] state_dbg
);

  localparam int LF    = at_least_one(LOCK_FILTER);
  localparam int SH    = at_least_one(SDRAM_HOLD);
  localparam int RT    = at_least_one(READY_TIMEOUT);
  localparam int CNT_W = at_least_one($clog2(max3(LF, SH, RT)));

  localparam logic [CNT_W-1:0] LF_LAST = CNT_W'(LF - 1);
  localparam logic [CNT_W-1:0] SH_LAST = CNT_W'(SH - 1);
  localparam logic [CNT_W-1:0] RT_LAST = CNT_W'(RT - 1);

  logic             locked_s;
  logic             btn_s;
  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             abort_s;
  logic             timeout_hit_s;
  logic             counting_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (locked_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_btn (
    .clk   (clk),
    .reset (reset),
    .d     (btn_reset),
    .q     (btn_s)
  );

  // Next-state decode; an abort overrides every other transition.
  always_comb begin
    state_nxt_s   = state_r;
    timeout_hit_s = 1'b0;
    abort_s       = (state_r != ST_WAIT_LOCK) && (!locked_s || btn_s);
    if (abort_s) begin
      state_nxt_s = ST_WAIT_LOCK;
    end else begin
      case (state_r)
        ST_WAIT_LOCK: begin
          if (locked_s && !btn_s) begin
            state_nxt_s = ST_FILTER;
          end else begin
            state_nxt_s = ST_WAIT_LOCK;
          end
        end
        ST_FILTER: begin
          if (cnt_r == LF_LAST) begin
            state_nxt_s = ST_SDRAM_RST;
          end else begin
            state_nxt_s = ST_FILTER;
          end
        end
        ST_SDRAM_RST: begin
          if (cnt_r == SH_LAST) begin
            state_nxt_s = ST_WAIT_READY;
          end else begin
            state_nxt_s = ST_SDRAM_RST;
          end
        end
        ST_WAIT_READY: begin
          // sdram_ready wins over a coincident timeout.
          if (sdram_ready) begin
            state_nxt_s = ST_RUN;
          end else if (cnt_r == RT_LAST) begin
            state_nxt_s   = ST_RUN;
            timeout_hit_s = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT_READY;
          end
        end
        ST_RUN: begin
          state_nxt_s = ST_RUN;
        end
        default: begin
          state_nxt_s = ST_WAIT_LOCK;
        end
      endcase
    end
  end

  // The counter only runs in the timed states and never outlives a state.
  always_comb begin
    case (state_r)
      ST_FILTER, ST_SDRAM_RST, ST_WAIT_READY: counting_s = 1'b1;
      default:                                counting_s = 1'b0;
    endcase
  end

  // State, counter, status and outputs (decoded from next state so they
  // switch on the same edge as the state register).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_WAIT_LOCK;
      cnt_r         <= '0;
      sdram_reset   <= 1'b1;
      core_reset_n  <= 1'b0;
      ready_timeout <= 1'b0;
      relock_count  <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_nxt_s == state_r) && counting_s) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= '0;
      end
      sdram_reset  <= (state_nxt_s == ST_WAIT_LOCK) || (state_nxt_s == ST_FILTER) ||
                      (state_nxt_s == ST_SDRAM_RST);
      core_reset_n <= (state_nxt_s == ST_RUN);
      if (timeout_hit_s) begin
        ready_timeout <= 1'b1;
      end else if ((state_nxt_s == ST_SDRAM_RST) && (state_r != ST_SDRAM_RST)) begin
        ready_timeout <= 1'b0;
      end
      if (abort_s && (relock_count != 8'hFF)) begin
        relock_count <= relock_count + 8'd1;
      end
    end
  end

  assign state_dbg = state_r;

endmodule
